// File: rtl/mux_arb.sv
// Two-channel arbiter driving a registered shared data mux.
// Grants alternate on ties, are bounded to MAX_HOLD cycles, and hand over to a waiting channel without an idle cycle.
//
// state | meaning
// IDLE  | no channel granted; arbitrate requests using prio on a tie
// GNT1  | channel 1 owns the mux (gnt1=1, sel=0)
// GNT2  | channel 2 owns the mux (gnt2=1, sel=1)
module mux_arb #(
    parameter int DATA_W   = 8,
    parameter int MAX_HOLD = 16
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              req1,
    input  logic              req2,
    input  logic              last1,
    input  logic              last2,
    input  logic [DATA_W-1:0] in1,
    input  logic [DATA_W-1:0] in2,
    output logic              gnt1,
    output logic              gnt2,
    output logic              sel,
    output logic [DATA_W-1:0] out,
    output logic              out_valid
);

    // State bits double as the grant outputs, so each grant comes straight from a flop.
    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_GNT1 = 2'b01;
    localparam logic [1:0] ST_GNT2 = 2'b10;

    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    logic [1:0]        state_q, state_d;
    logic              prio_q, prio_d;
    logic [7:0]        hold_q, hold_d;
    logic              sel_q, sel_d;
    logic [DATA_W-1:0] out_q, out_d;
    logic              out_valid_q, out_valid_d;
    logic              timeout;

    always_comb begin
        state_d     = state_q;
        prio_d      = prio_q;
        hold_d      = hold_q;
        sel_d       = sel_q;
        out_d       = out_q;
        out_valid_d = (state_q != ST_IDLE);
        timeout     = (hold_q == HOLD_LAST);

        case (state_q)
            ST_IDLE: begin
                if (req1 && (!req2 || !prio_q)) begin
                    state_d = ST_GNT1;
                end else if (req2) begin
                    state_d = ST_GNT2;
                end
            end
            ST_GNT1: begin
                if (last1 || !req1 || timeout) begin
                    state_d = req2 ? ST_GNT2 : ST_IDLE;
                end
            end
            ST_GNT2: begin
                if (last2 || !req2 || timeout) begin
                    state_d = req1 ? ST_GNT1 : ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A release never re-enters the same grant state directly, so any change of state is a grant entry or exit.
        if (state_d != state_q) begin
            hold_d = 8'd0;
            if (state_d == ST_GNT1) begin
                prio_d = 1'b1;
                sel_d  = 1'b0;
            end else if (state_d == ST_GNT2) begin
                prio_d = 1'b0;
                sel_d  = 1'b1;
            end
        end else if (state_q != ST_IDLE) begin
            hold_d = hold_q + 8'd1;
        end

        if (state_q != ST_IDLE) begin
            out_d = sel_q ? in2 : in1;
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q     <= ST_IDLE;
            prio_q      <= 1'b0;
            hold_q      <= 8'd0;
            sel_q       <= 1'b0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            prio_q      <= prio_d;
            hold_q      <= hold_d;
            sel_q       <= sel_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign gnt1      = state_q[0];
    assign gnt2      = state_q[1];
    assign sel       = sel_q;
    assign out       = out_q;
    assign out_valid = out_valid_q;

endmodule

// File: doc/mux_arb.md
MUX_ARB -- requirements
Module: mux_arb

Interface
REQ-001 Parameter DATA_W, default 8, width of each data input and of the data output.
REQ-002 Parameter MAX_HOLD, default 16, maximum consecutive granted cycles per grant; legal range 2..255.
REQ-003 sys_clk  input  1  single clock; all state updates on its rising edge.
REQ-004 sys_rst  input  1  reset, asynchronous and active-high.
REQ-005 req1  input  1  channel 1 requests the shared mux.
REQ-006 req2  input  1  channel 2 requests the shared mux.
REQ-007 last1  input  1  channel 1 final beat; sampled only while gnt1=1.
REQ-008 last2  input  1  channel 2 final beat; sampled only while gnt2=1.
REQ-009 in1  input  DATA_W  channel 1 data.
REQ-010 in2  input  DATA_W  channel 2 data.
REQ-011 gnt1  output  1  registered grant to channel 1.
REQ-012 gnt2  output  1  registered grant to channel 2.
REQ-013 sel  output  1  registered mux select: 0 = in1, 1 = in2.
REQ-014 out  output  DATA_W  registered muxed data.
REQ-015 out_valid  output  1  registered; out holds a granted beat.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, GNT1, GNT2. gnt1=1 only in GNT1, gnt2=1 only in GNT2. gnt1 and gnt2 are never both 1.
REQ-017 A priority flag (prio) SHALL select the winner on a tie: prio=0 favours channel 1 and prio=1 favours channel 2. prio is updated on every grant entry to favour the other channel.
REQ-018 IDLE: exactly one request -> grant that channel next cycle. Both requests -> grant per prio next cycle. No request -> stay in IDLE.
REQ-019 A grant decision SHALL take effect one cycle after the request is sampled. Minimum request-to-grant latency is 1 cycle.
REQ-020 A hold counter SHALL clear to 0 on grant entry and increment on each granted cycle.
REQ-021 In GNTn, the grant SHALL release at the end of a cycle where any of these holds: last_n=1, req_n=0, or hold counter = MAX_HOLD-1.
REQ-022 On release, if the other channel requests, the FSM SHALL go directly to its grant state with no idle bubble. Otherwise it SHALL go to IDLE.
REQ-023 On release by timeout, the releasing channel SHALL not be re-granted next cycle if the other channel requests. If it alone requests, it SHALL be re-granted after one IDLE cycle.
REQ-024 sel SHALL update in the same cycle as the grant: 0 in GNT1, 1 in GNT2. In IDLE, sel keeps its last value.
REQ-025 out(t+1) SHALL equal (sel ? in2 : in1) sampled at t, and out_valid(t+1) SHALL equal gnt1|gnt2 at t. Data latency is 1 cycle.
REQ-026 When out_valid=0, out SHALL hold its previous value.
REQ-027 last_n or req_n asserted by a channel that is not granted SHALL have no effect on the current grant.
REQ-028 A release condition and a new request in the same cycle SHALL be resolved by REQ-022 only. A fresh request never extends a released grant.

Reset
REQ-029 While sys_rst=1, the block SHALL be in IDLE with prio=0, hold counter=0, gnt1=0, gnt2=0, sel=0, out=0, out_valid=0.
REQ-030 Reset asserted mid-grant SHALL drop the grant immediately, without waiting for a clock edge.
REQ-031 After reset deasserts, the first arbitration SHALL occur on the next rising edge.

Verification
REQ-032 Release reset; req1=1 only, in1=8'hA5, last1 at 3rd granted cycle -> gnt1 high 1 cycle after req1 for 3 cycles. out=8'hA5 with out_valid=1 for 3 cycles, lagging grant by 1 cycle. Then IDLE.
REQ-033 req1=req2=1 from reset, each with last on 2nd beat -> grant order GNT1(2), GNT2(2), GNT1(2). No IDLE cycle between grants. sel toggles 0,1,0.
REQ-034 MAX_HOLD=4; req2 held with last2=0 and req1=1 -> gnt2 exactly 4 cycles, then gnt1 next cycle.
REQ-035 req1 held alone, last1=0, MAX_HOLD=4 -> 4 granted cycles, 1 IDLE cycle, re-grant. out_valid=0 for exactly 1 cycle.
REQ-036 sys_rst asserted asynchronously mid-GNT2 -> gnt2, sel, out_valid go to 0 before the next sys_clk edge. After release, req2 alone -> granted 1 cycle later.
REQ-037 Every cycle: gnt1&gnt2=0, and out_valid(t+1)=gnt1|gnt2 at t.
